// File: rtl/serial_adder_if.sv
// ============================================================================
// Module      : serial_adder_if
// Description : Start/busy/done handshake and operand/result bundle for
//               serial_adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, s, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, s, cout, ovf
    );
endinterface

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module      : serial_adder
// Description : Multi-cycle LSB-first adder/subtractor, DIGIT bits per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    serial_adder_if.slave   bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    logic [DIGIT:0]   w_slice;
    logic             w_cmsb;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    assign w_slice = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, r_carry};
    // Carry into the slice MSB recovered from its sum bit and operand bits.
    assign w_cmsb  = w_slice[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];
    assign w_last  = (r_cnt == CNT_W'(N - 1));

    generate
        if (DIGIT == WIDTH) begin : g_single
            assign w_res_next = w_slice[DIGIT-1:0];
        end else begin : g_multi
            logic [WIDTH-DIGIT-1:0] r_part;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_part <= '0;
                end else if (r_state == S_RUN) begin
                    r_part <= w_res_next[WIDTH-1:DIGIT];
                end
            end

            assign w_res_next = {w_slice[DIGIT-1:0], r_part};
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.sub ? ~bus.b : bus.b;
                        r_carry <= bus.cin ^ bus.sub;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_slice[DIGIT];
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_s    <= w_res_next;
                        r_cout <= w_slice[DIGIT];
                        r_ovf  <= w_cmsb ^ w_slice[DIGIT];
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.done = r_done;
    assign bus.s    = r_s;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module      : tb_serial_adder
// Description : Randomised self-checking bench for serial_adder, three configs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) if81 ();
    serial_adder_if #(.WIDTH(8)) if84 ();
    serial_adder_if #(.WIDTH(2)) if21 ();

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_81 (.clk(clk), .rst_n(rst_n), .bus(if81));
    serial_adder #(.WIDTH(8), .DIGIT(4)) u_84 (.clk(clk), .rst_n(rst_n), .bus(if84));
    serial_adder #(.WIDTH(2), .DIGIT(1)) u_21 (.clk(clk), .rst_n(rst_n), .bus(if21));

    // Reference: plain integer arithmetic, returns {ovf, cout, s}.
    function automatic logic [9:0] model(input int w, input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic sub);
        int mask, ai, bi, sa, sb, r, sr;
        logic co, ov;
        logic [7:0] s;
        mask = (1 << w) - 1;
        ai = int'(a) & mask;
        bi = int'(b) & mask;
        sa = (ai >= (1 << (w - 1))) ? ai - (1 << w) : ai;
        sb = (bi >= (1 << (w - 1))) ? bi - (1 << w) : bi;
        if (!sub) begin
            r  = ai + bi + int'(cin);
            co = (r >= (1 << w));
            sr = sa + sb + int'(cin);
        end else begin
            r  = ai - bi - int'(cin);
            co = (r >= 0);
            sr = sa - sb - int'(cin);
        end
        ov = (sr > (1 << (w - 1)) - 1) || (sr < -(1 << (w - 1)));
        s  = 8'(r & mask);
        return {ov, co, s};
    endfunction

    task automatic drive(input int sel, input logic st, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub);
        case (sel)
            0: begin if81.start = st; if81.a = a; if81.b = b; if81.cin = cin; if81.sub = sub; end
            1: begin if84.start = st; if84.a = a; if84.b = b; if84.cin = cin; if84.sub = sub; end
            default: begin
                if21.start = st; if21.a = a[1:0]; if21.b = b[1:0]; if21.cin = cin; if21.sub = sub;
            end
        endcase
    endtask

    task automatic sample(input int sel, output logic bz, output logic dn, output logic [7:0] s,
                          output logic co, output logic ov);
        case (sel)
            0: begin bz = if81.busy; dn = if81.done; s = if81.s; co = if81.cout; ov = if81.ovf; end
            1: begin bz = if84.busy; dn = if84.done; s = if84.s; co = if84.cout; ov = if84.ovf; end
            default: begin
                bz = if21.busy; dn = if21.done; s = {6'b0, if21.s}; co = if21.cout; ov = if21.ovf;
            end
        endcase
    endtask

    // Launch one operation; lat counts edges after the accepting edge (-1 on timeout).
    task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sub, output logic [9:0] res, output int lat, output int bcnt);
        logic bz, dn, co, ov;
        logic [7:0] s;
        @(negedge clk);
        drive(sel, 1'b1, a, b, cin, sub);
        @(negedge clk);
        drive(sel, 1'b0, a, b, cin, sub);
        lat = 0;
        bcnt = 0;
        sample(sel, bz, dn, s, co, ov);
        while (!dn && lat < 50) begin
            if (bz) bcnt++;
            @(negedge clk);
            lat++;
            sample(sel, bz, dn, s, co, ov);
        end
        if (!dn) lat = -1;
        res = {ov, co, s};
    endtask

    task automatic test_reset;
        logic bz, dn, co, ov;
        logic [7:0] s;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        #3;
        for (int i = 0; i < 3; i++) begin
            sample(i, bz, dn, s, co, ov);
            total++;
            if ({bz, dn, s, co, ov} !== 12'h000) begin
                bad++;
                $display("FAIL reset_state dut=%0d got=%h want=000", i, {bz, dn, s, co, ov});
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed8;
        logic [9:0] res;
        int lat, bcnt;
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, res, lat, bcnt);
        total++;
        if (res !== {1'b0, 1'b1, 8'h00}) begin
            bad++; $display("FAIL add_ff_01 got=%h want=%h", res, {2'b01, 8'h00});
        end
        total++;
        if (lat !== 8 || bcnt !== 8) begin
            bad++; $display("FAIL latency_busy_8 got lat=%0d busy=%0d want 8/8", lat, bcnt);
        end
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, res, lat, bcnt);
        total++;
        if (res !== {1'b1, 1'b0, 8'h80}) begin
            bad++; $display("FAIL add_7f_01 got=%h want=%h", res, {2'b10, 8'h80});
        end
        run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, res, lat, bcnt);
        total++;
        if (res !== {1'b0, 1'b0, 8'hFE}) begin
            bad++; $display("FAIL sub_05_07 got=%h want=%h", res, {2'b00, 8'hFE});
        end
    endtask

    task automatic test_digit4;
        logic [9:0] res;
        int lat, bcnt;
        run_op(1, 8'h3C, 8'h0F, 1'b1, 1'b0, res, lat, bcnt);
        total++;
        if (res !== {1'b0, 1'b0, 8'h4C} || lat !== 2) begin
            bad++; $display("FAIL digit4_3c_0f got=%h lat=%0d want=%h lat=2", res, lat, {2'b00, 8'h4C});
        end
    endtask

    task automatic test_random;
        logic [9:0] res, exp;
        logic [7:0] a, b;
        int lat, bcnt;
        for (int sel = 0; sel < 2; sel++) begin
            for (int k = 0; k < 4; k++) begin
                for (int r = 0; r < 6; r++) begin
                    a = 8'($urandom);
                    b = 8'($urandom);
                    exp = model(8, a, b, k[0], k[1]);
                    run_op(sel, a, b, k[0], k[1], res, lat, bcnt);
                    total++;
                    if (res !== exp || lat !== (sel == 0 ? 8 : 2)) begin
                        bad++;
                        $display("FAIL random dut=%0d a=%h b=%h cin=%0d sub=%0d got=%h lat=%0d want=%h",
                                 sel, a, b, k[0], k[1], res, lat, exp);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic bz, dn, co, ov;
        logic [7:0] s;
        logic [9:0] e1, e2;
        int lat;
        e1 = model(8, 8'hA5, 8'h3C, 1'b1, 1'b0);
        e2 = model(8, 8'h5A, 8'hC3, 1'b0, 1'b1);
        @(negedge clk);
        drive(0, 1'b1, 8'hA5, 8'h3C, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0);
        lat = 0;
        sample(0, bz, dn, s, co, ov);
        while (!dn && lat < 50) begin
            if (lat == 3) drive(0, 1'b1, 8'h11, 8'h11, 1'b0, 1'b1);
            else if (lat == 4) drive(0, 1'b0, 8'h11, 8'h11, 1'b0, 1'b1);
            @(negedge clk);
            lat++;
            sample(0, bz, dn, s, co, ov);
        end
        total++;
        if ({ov, co, s} !== e1 || lat !== 8) begin
            bad++; $display("FAIL start_ignored got=%h lat=%0d want=%h lat=8", {ov, co, s}, lat, e1);
        end
        // Start raised inside the done cycle.
        drive(0, 1'b1, 8'h5A, 8'hC3, 1'b0, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 8'h5A, 8'hC3, 1'b0, 1'b1);
        lat = 0;
        sample(0, bz, dn, s, co, ov);
        total++;
        if (bz !== 1'b1 || dn !== 1'b0 || {ov, co, s} !== e1) begin
            bad++; $display("FAIL b2b_accept_hold busy=%b done=%b got=%h want=%h", bz, dn, {ov, co, s}, e1);
        end
        while (!dn && lat < 50) begin
            @(negedge clk);
            lat++;
            sample(0, bz, dn, s, co, ov);
        end
        total++;
        if ({ov, co, s} !== e2 || lat !== 8) begin
            bad++; $display("FAIL b2b_second got=%h lat=%0d want=%h lat=8", {ov, co, s}, lat, e2);
        end
        @(negedge clk);
        sample(0, bz, dn, s, co, ov);
        total++;
        if (dn !== 1'b0 || bz !== 1'b0 || {ov, co, s} !== e2) begin
            bad++; $display("FAIL done_pulse_hold done=%b busy=%b got=%h want=%h", dn, bz, {ov, co, s}, e2);
        end
    endtask

    task automatic test_async_reset;
        logic bz, dn, co, ov;
        logic [7:0] s;
        logic [9:0] res;
        int lat, bcnt, dones;
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, res, lat, bcnt);
        @(negedge clk);
        drive(0, 1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 8'hFF, 8'h01, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        sample(0, bz, dn, s, co, ov);
        total++;
        if ({bz, dn, s, co, ov} !== 12'h000) begin
            bad++; $display("FAIL async_reset got=%h want=000", {bz, dn, s, co, ov});
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            sample(0, bz, dn, s, co, ov);
            if (dn || bz) dones++;
        end
        total++;
        if (dones !== 0 || {s, co, ov} !== 10'h000) begin
            bad++; $display("FAIL after_reset activity=%0d got=%h want=000", dones, {s, co, ov});
        end
        run_op(0, 8'h12, 8'h34, 1'b1, 1'b0, res, lat, bcnt);
        total++;
        if (res !== model(8, 8'h12, 8'h34, 1'b1, 1'b0) || lat !== 8) begin
            bad++; $display("FAIL post_reset_op got=%h lat=%0d want=%h", res, lat, model(8, 8'h12, 8'h34, 1'b1, 1'b0));
        end
    endtask

    task automatic test_exhaustive2;
        logic [9:0] res, exp;
        int lat, bcnt;
        for (int v = 0; v < 64; v++) begin
            exp = model(2, 8'(v & 3), 8'((v >> 2) & 3), v[4], v[5]);
            run_op(2, 8'(v & 3), 8'((v >> 2) & 3), v[4], v[5], res, lat, bcnt);
            total++;
            if (res !== exp || lat !== 2) begin
                bad++;
                $display("FAIL w2_exhaustive v=%0d got=%h lat=%0d want=%h", v, res, lat, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed8();
        test_digit4();
        test_random();
        test_back_to_back();
        test_async_reset();
        test_exhaustive2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor, the sequential successor to the single-bit full adder.
- Operands of WIDTH bits are processed LSB-first, DIGIT bits per clock, through one DIGIT-wide ripple slice and a registered carry.
- Start/busy/done handshake lets a controller or testbench launch one operation and collect sum, carry and signed overflow.

Parameters:
- WIDTH, 8: operand and result width in bits. Must be ≥ 2.
- DIGIT, 1: bits processed per cycle. WIDTH % DIGIT must equal 0.
- N (localparam), WIDTH/DIGIT: cycles per operation.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a new operation; sampled only when busy=0
- a  in  WIDTH  operand A, captured on the accepting edge
- b  in  WIDTH  operand B, captured on the accepting edge
- cin  in  1  carry-in (add) or borrow-in (sub), captured on the accepting edge
- sub  in  1  0 = a+b+cin; 1 = a-b-cin; captured on the accepting edge
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: result valid and updated
- s  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  raw carry out of the MSB
- ovf  out  1  two's-complement overflow

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, s, cout, ovf all 0; internal shift registers and carry cleared. Takes effect immediately, independent of clk.
- Reset mid-operation aborts the operation: no done, outputs stay 0.
- States: IDLE and RUN only.
- IDLE → RUN on a rising edge with start=1. On that edge:
  - latch a and b (b inverted when sub=1);
  - carry register ← (sub ? ~cin : cin);
  - digit counter ← 0; busy ← 1.
- start is ignored while busy=1; latched operands are unaffected.
- RUN, each edge:
  - add the low DIGIT bits of both shift registers plus the carry register;
  - shift the sum digit into the result shift register from the MSB side;
  - update the carry register; increment the counter.
- Final digit (counter = N-1):
  - s ← assembled result; cout ← carry out of bit WIDTH-1;
  - ovf ← carry into bit WIDTH-1 XOR carry out of bit WIDTH-1;
  - done ← 1 for exactly one cycle; busy ← 0; state → IDLE.
- Latency: start accepted at edge k → done high after edge k+N. busy is high for N cycles.
  - DIGIT=WIDTH gives N=1: done follows the accepting edge by one edge.
- Back-to-back: start=1 in the cycle where done=1 (busy=0) is accepted. The next done follows N edges later, with no idle gap.
- Output holding: s, cout and ovf update only on the completion edge. They hold their value through later RUN cycles and IDLE until the next completion.
- Subtract semantics:
  - s = a - b - cin mod 2^WIDTH;
  - cout = NOT borrow (cout=1 means no borrow);
  - ovf uses the same XOR rule on the inverted-b path.
- Width rule: all internal arithmetic is exactly DIGIT+1 bits per slice. No result bits beyond WIDTH are kept, apart from cout.

Test Plan:
- WIDTH=8, DIGIT=1, add a=8'hFF b=8'h01 cin=0 → after 8 edges: done pulse, s=8'h00, cout=1, ovf=0; busy high for exactly 8 cycles.
- WIDTH=8, DIGIT=1, add a=8'h7F b=8'h01 cin=0 → s=8'h80, cout=0, ovf=1. Then sub a=8'h05 b=8'h07 cin=0 → s=8'hFE, cout=0, ovf=0.
- WIDTH=8, DIGIT=4, add a=8'h3C b=8'h0F cin=1 → done after 2 edges, s=8'h4C, cout=0, ovf=0. Sweep all {cin,sub} combinations with random operands against a reference model.
- Start re-asserted with new operands (a=8'h11) on cycle 3 of a running operation → ignored; the original result is produced. Then start in the done cycle → accepted, second done exactly N edges later.
- rst_n pulled low asynchronously mid-RUN (between edges) → busy, done, s, cout, ovf go to 0 immediately; no done after release; the next start completes normally.
- WIDTH=2, DIGIT=1: exhaustive check of all 2^6 combinations of a, b, cin, sub → s, cout and ovf match the arithmetic definition.
